serial_deserializer: RTL
========================

Name: serial_deserializer

Overview:
Serial-to-parallel receive stage that sits directly downstream of the D flip-flop cell. It consumes the registered serial bit stream (one bit per qualified clock edge) and assembles it into a WIDTH-bit word. It then checks a trailing stop bit and presents the word with a one-cycle VALID pulse to the next stage. It is built as a shift chain plus a bit counter and a 3-state FSM, all on the same clock as the flip-flop stage.

Parameters:
WIDTH, 8, data bits per frame; legal range 2..15.
MSB_FIRST, 1, 1 = first received bit lands in Q[WIDTH-1]; 0 = first bit lands in Q[0].

Ports:
C  input  1  clock; all state changes on the rising edge.
R  input  1  reset; synchronous, active-high.
EN  input  1  bit strobe; D is sampled only on edges where EN=1.
START  input  1  frame start request; honoured only in IDLE.
D  input  1  serial data, driven by the upstream D flip-flop Q output.
Q  output  WIDTH  last successfully received word.
VALID  output  1  one-cycle pulse: Q has just been updated.
ERR  output  1  one-cycle pulse: stop bit was 0 and the frame is discarded.
BUSY  output  1  high in DATA and STOP states.
CNT  output  4  number of data bits captured in the current frame.

Behaviour:
- Decided interface: one clock, C. Reset R is synchronous and active-high.
- Reset, on any edge with R=1, regardless of state or any other input:
  - state returns to IDLE.
  - Q=0, the internal shift register=0, CNT=0.
  - VALID=0, ERR=0, BUSY=0.
  - An asserted reset mid-frame abandons the frame without raising VALID or ERR.
- FSM states are IDLE, DATA and STOP.
- IDLE:
  - START=1 moves to DATA; CNT and the shift register clear to 0.
  - EN and D are ignored in IDLE.
  - START=1 together with EN=1 in the same cycle does not capture a bit.
- DATA, on each edge with EN=1:
  - MSB_FIRST=1: shift register <= {sr[WIDTH-2:0], D}.
  - MSB_FIRST=0: shift register <= {D, sr[WIDTH-1:1]}.
  - CNT increments by 1.
  - When CNT reaches WIDTH on that edge, move to STOP.
  - EN=0 holds all state. START is ignored.
- STOP, on the first edge with EN=1:
  - D=1: Q <= shift register and VALID=1 for exactly the next cycle.
  - D=0: Q unchanged and ERR=1 for exactly the next cycle.
  - Either way, return to IDLE with CNT=0.
- Pulse and busy timing:
  - VALID and ERR are registered and never high simultaneously.
  - BUSY is registered and reflects the current state.
- START may be asserted in the cycle VALID/ERR is high; the FSM is already in IDLE, so back-to-back frames have zero dead cycles.
- Latency: VALID rises one clock after the edge that samples the stop bit.
- Q holds its value indefinitely between frames and after an ERR.

Test Plan:
1. R=1 for 2 edges with START=1, EN=1, D=1 -> Q=0x00, CNT=0, VALID=ERR=BUSY=0 throughout.
2. MSB_FIRST=1: START, then EN=1 for 8 cycles with D=1,0,1,0,0,1,0,1, then stop bit D=1 -> BUSY high for 9 cycles, CNT counts 1..8, Q=0xA5, VALID high for 1 cycle only.
3. Same frame with stop bit D=0 -> ERR pulses once, VALID stays 0, Q retains the prior value 0xA5 from scenario 2.
4. MSB_FIRST=0, same bit sequence 1,0,1,0,0,1,0,1 with EN toggling 1/0 every cycle -> Q=0xA5 after the stop bit; CNT changes only on EN=1 edges; total frame time is 18 cycles.
5. Reset mid-frame: START, 4 bits, then R=1 for 1 edge -> IDLE, CNT=0, Q=0, no VALID/ERR. A following full frame of 0x3C is received correctly.
6. Back-to-back: START asserted in the VALID cycle of frame 0x5A, then frame 0xFF -> two VALID pulses 10 cycles apart, Q=0x5A then Q=0xFF.

Source files
------------

// File: rtl/serial_deserializer_if.sv
// Bundle of bit-stream inputs and word outputs for the serial deserializer.
`default_nettype none

interface serial_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             START;
  logic             D;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             ERR;
  logic             BUSY;
  logic [3:0]       CNT;

  modport master (
    output EN, START, D,
    input  Q, VALID, ERR, BUSY, CNT
  );

  modport slave (
    input  EN, START, D,
    output Q, VALID, ERR, BUSY, CNT
  );
endinterface

`default_nettype wire

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receive stage: shift chain, bit counter and IDLE/DATA/STOP FSM
// assembling WIDTH data bits and validating a trailing stop bit.
`default_nettype none

module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  C,
  input  logic                  R,
  serial_deserializer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, sr_shift;
  logic [WIDTH-1:0] q, q_n;
  logic [3:0]       cnt, cnt_n;
  logic             valid, valid_n;
  logic             err, err_n;
  logic             busy, busy_n;

  // Bit order is fixed at elaboration; only the shift direction differs.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shift = {sr[WIDTH-2:0], bus.D};
    end else begin : g_lsb_first
      assign sr_shift = {bus.D, sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge C) begin
    if (R) begin
      state <= IDLE;
      sr    <= '0;
      q     <= '0;
      cnt   <= 4'd0;
      valid <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      q     <= q_n;
      cnt   <= cnt_n;
      valid <= valid_n;
      err   <= err_n;
      busy  <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    q_n     = q;
    cnt_n   = cnt;
    valid_n = 1'b0;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.START) begin
          state_n = DATA;
          sr_n    = '0;
          cnt_n   = 4'd0;
        end
      end
      DATA: begin
        if (bus.EN) begin
          sr_n  = sr_shift;
          cnt_n = cnt + 4'd1;
          if (cnt_n == LAST_CNT) begin
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (bus.EN) begin
          // A bad stop bit discards the frame but leaves the last good word on Q.
          if (bus.D) begin
            q_n     = sr;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.Q     = q;
  assign bus.VALID = valid;
  assign bus.ERR   = err;
  assign bus.BUSY  = busy;
  assign bus.CNT   = cnt;

endmodule

`default_nettype wire
